apu_pulse_reg_writer: RTL and testbench
=======================================

Name: apu_pulse_reg_writer

Overview:
- CPU-side write end of the pulse-channel register interface.
- Decodes CPU bus writes to $4000-$4007 and $4015 and holds the eight pulse register bytes that drive the two pulse channels.
- Generates the one-cycle side-effect strobes the channels need on register writes.
- Owns both 5-bit-indexed length counters, and returns channel status on $4015 reads.

Parameters:
- BASE_ADDR, 16'h4000: address of pulse 1 register 0. Pulse 2 is at BASE_ADDR+4.
- STATUS_ADDR, 16'h4015: status/enable register address.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_data_in  in  8  CPU write data.
- cpu_we  in  1  write strobe, sampled on posedge.
- cpu_re  in  1  read strobe, sampled on posedge.
- cpu_data_out  out  8  registered read data.
- half_frame_tick  in  1  one-cycle length-counter clock from the frame sequencer.
- reg4000..reg4003  out  8 each  pulse 1 register bytes.
- reg4004..reg4007  out  8 each  pulse 2 register bytes.
- p1_restart, p2_restart  out  1  one-cycle strobe after a write to $4003 / $4007.
- p1_sweep_reload, p2_sweep_reload  out  1  one-cycle strobe after a write to $4001 / $4005.
- p1_active, p2_active  out  1  length counter of that channel is nonzero.

Behaviour:
- Reset (synchronous, while reset=1):
  - all reg400x = 8'h00, cpu_data_out = 0, all strobes = 0.
  - both length counters = 0, both enable bits = 0.
  - reset overrides any same-cycle write, read or tick.
  - reset mid-operation discards pending state with no partial update.
- Write decode:
  - a write occurs when cpu_we=1 and cpu_addr is in BASE_ADDR..BASE_ADDR+7 or equals STATUS_ADDR.
  - the addressed byte updates on that posedge and is visible on reg400x the following cycle (1-cycle latency).
  - other addresses are ignored.
- Strobes:
  - p1/p2_restart and p1/p2_sweep_reload are high for exactly one cycle, coincident with the updated register output.
  - back-to-back writes give back-to-back strobes with no merging.
- Length table, indexed by data[7:3] of a $4003/$4007 write:
  - indices 0-15: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14
  - indices 16-31: 12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30
- Length counters (8-bit, one per channel):
  - Load: a write to $4003/$4007 loads table[data[7:3]] if that channel's enable bit is 1. The write is ignored by the counter if enable=0; the register byte still updates.
  - Decrement: on half_frame_tick, if counter != 0 and halt = 0, counter -= 1. Halt is bit 5 of $4000 / $4004 as currently held. A counter at 0 stays at 0; there is no wrap.
  - Simultaneous load and tick on the same edge: load wins and no decrement occurs.
- $4015 write:
  - bit0 = pulse 1 enable, bit1 = pulse 2 enable; other bits ignored.
  - writing 0 to an enable bit forces that counter to 0 on the same edge, overriding a same-cycle tick.
  - if the $4015 write and a $4003 write fall in the same cycle, only one address is possible, so no conflict exists.
- active outputs: p1_active = (len1 != 0), p2_active = (len2 != 0). Both are combinational from the counter registers.
- Reads:
  - cpu_re=1 with cpu_addr = STATUS_ADDR sets cpu_data_out to {6'b0, p2_active, p1_active} on the next cycle.
  - any other read, or no read, gives cpu_data_out = 0 on the next cycle.
  - if cpu_we and cpu_re are both 1, the write is performed and cpu_data_out = 0.
  - the pulse registers are write-only and read back as 0.

Test Plan:
- Reset, then write $4002=8'hA5 -> reg4002=8'hA5 one cycle later; all other regs 0; no strobes.
- Write $4015=8'h01, then $4003=8'h08 (index 1) -> reg4003=8'h08, p1_restart high for 1 cycle, len1=254, p1_active=1. Write $4007=8'h08 with p2 disabled -> p2_restart pulses, p2_active stays 0.
- With $4000=8'h00 and len1=2, apply two half_frame_tick -> len1 goes 1 then 0, p1_active=0. A third tick keeps 0. Repeat with $4000=8'h20 -> len1 is held.
- Assert half_frame_tick on the same cycle as a $4003 write with index 3 -> len1=2, not 1.
- len1=254, then write $4015=8'h00 concurrent with a tick -> len1=0 next cycle. A read of $4015 returns 8'h00, and 8'h01 before the disable.
- Assert reset mid-stream after loading both counters and writing $4001 (sweep strobe pending) -> next cycle all outputs 0, no strobe emitted.

Source files
------------

// File: rtl/apu_pulse_reg_writer.sv
// CPU-side write port of the two pulse channels: holds the $4000-$4007
// register bytes, raises one-cycle side-effect strobes on register writes,
// owns both length counters and answers $4015 status reads.
module apu_pulse_reg_writer #(
   parameter logic [15:0] BASE_ADDR   = 16'h4000,
   parameter logic [15:0] STATUS_ADDR = 16'h4015
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic [7:0]  cpu_data_out,
   input  logic        half_frame_tick,
   output logic [7:0]  reg4000,
   output logic [7:0]  reg4001,
   output logic [7:0]  reg4002,
   output logic [7:0]  reg4003,
   output logic [7:0]  reg4004,
   output logic [7:0]  reg4005,
   output logic [7:0]  reg4006,
   output logic [7:0]  reg4007,
   output logic        p1_restart,
   output logic        p2_restart,
   output logic        p1_sweep_reload,
   output logic        p2_sweep_reload,
   output logic        p1_active,
   output logic        p2_active
);

   // Length counter load values, indexed by data[7:3] of a $4003/$4007 write.
   function automatic logic [7:0] len_lookup(input logic [4:0] idx);
      logic [7:0] val;
      case (idx)
         5'd0:    val = 8'd10;
         5'd1:    val = 8'd254;
         5'd2:    val = 8'd20;
         5'd3:    val = 8'd2;
         5'd4:    val = 8'd40;
         5'd5:    val = 8'd4;
         5'd6:    val = 8'd80;
         5'd7:    val = 8'd6;
         5'd8:    val = 8'd160;
         5'd9:    val = 8'd8;
         5'd10:   val = 8'd60;
         5'd11:   val = 8'd10;
         5'd12:   val = 8'd14;
         5'd13:   val = 8'd12;
         5'd14:   val = 8'd26;
         5'd15:   val = 8'd14;
         5'd16:   val = 8'd12;
         5'd17:   val = 8'd16;
         5'd18:   val = 8'd24;
         5'd19:   val = 8'd18;
         5'd20:   val = 8'd48;
         5'd21:   val = 8'd20;
         5'd22:   val = 8'd96;
         5'd23:   val = 8'd22;
         5'd24:   val = 8'd192;
         5'd25:   val = 8'd24;
         5'd26:   val = 8'd72;
         5'd27:   val = 8'd26;
         5'd28:   val = 8'd16;
         5'd29:   val = 8'd28;
         5'd30:   val = 8'd32;
         5'd31:   val = 8'd30;
         default: val = 8'd0;
      endcase
      return val;
   endfunction

   logic [15:0] offset_s;
   logic [2:0]  reg_idx_s;
   logic        wr_pulse_s;
   logic        wr_status_s;
   logic        rd_status_s;
   logic [7:0]  len1_nxt_s;
   logic [7:0]  len2_nxt_s;

   logic [7:0]  reg_r [0:7];
   logic [7:0]  len1_r;
   logic [7:0]  len2_r;
   logic        en1_r;
   logic        en2_r;
   logic        p1_restart_r;
   logic        p2_restart_r;
   logic        p1_sweep_r;
   logic        p2_sweep_r;
   logic [7:0]  data_out_r;

   // Address decode: a pulse register write is any address within 8 bytes of the base.
   always_comb begin
      offset_s    = cpu_addr - BASE_ADDR;
      reg_idx_s   = offset_s[2:0];
      wr_pulse_s  = cpu_we && (offset_s < 16'd8);
      wr_status_s = cpu_we && (cpu_addr == STATUS_ADDR);
      rd_status_s = cpu_re && !cpu_we && (cpu_addr == STATUS_ADDR);
   end

   // Pulse register bytes: the addressed byte takes the write data.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            reg_r[i] <= 8'h00;
         end
      end else if (wr_pulse_s) begin
         reg_r[reg_idx_s] <= cpu_data_in;
      end
   end

   // Side-effect strobes, registered so they line up with the updated byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1_restart_r <= 1'b0;
         p2_restart_r <= 1'b0;
         p1_sweep_r   <= 1'b0;
         p2_sweep_r   <= 1'b0;
      end else begin
         p1_restart_r <= wr_pulse_s && (reg_idx_s == 3'd3);
         p2_restart_r <= wr_pulse_s && (reg_idx_s == 3'd7);
         p1_sweep_r   <= wr_pulse_s && (reg_idx_s == 3'd1);
         p2_sweep_r   <= wr_pulse_s && (reg_idx_s == 3'd5);
      end
   end

   // Next length values: disable beats load, load beats a half-frame decrement.
   always_comb begin
      len1_nxt_s = len1_r;
      len2_nxt_s = len2_r;
      if (wr_status_s && !cpu_data_in[0]) begin
         len1_nxt_s = 8'd0;
      end else if (wr_pulse_s && (reg_idx_s == 3'd3) && en1_r) begin
         len1_nxt_s = len_lookup(cpu_data_in[7:3]);
      end else if (half_frame_tick && (len1_r != 8'd0) && !reg_r[0][5]) begin
         len1_nxt_s = len1_r - 8'd1;
      end else begin
         len1_nxt_s = len1_r;
      end
      if (wr_status_s && !cpu_data_in[1]) begin
         len2_nxt_s = 8'd0;
      end else if (wr_pulse_s && (reg_idx_s == 3'd7) && en2_r) begin
         len2_nxt_s = len_lookup(cpu_data_in[7:3]);
      end else if (half_frame_tick && (len2_r != 8'd0) && !reg_r[4][5]) begin
         len2_nxt_s = len2_r - 8'd1;
      end else begin
         len2_nxt_s = len2_r;
      end
   end

   // Length counters and channel enable bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         len1_r <= 8'd0;
         len2_r <= 8'd0;
         en1_r  <= 1'b0;
         en2_r  <= 1'b0;
      end else begin
         len1_r <= len1_nxt_s;
         len2_r <= len2_nxt_s;
         if (wr_status_s) begin
            en1_r <= cpu_data_in[0];
            en2_r <= cpu_data_in[1];
         end
      end
   end

   // Read data: only a pure $4015 read returns status; everything else reads 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_r <= 8'h00;
      end else if (rd_status_s) begin
         data_out_r <= {6'b000000, (len2_r != 8'd0), (len1_r != 8'd0)};
      end else begin
         data_out_r <= 8'h00;
      end
   end

   assign reg4000         = reg_r[0];
   assign reg4001         = reg_r[1];
   assign reg4002         = reg_r[2];
   assign reg4003         = reg_r[3];
   assign reg4004         = reg_r[4];
   assign reg4005         = reg_r[5];
   assign reg4006         = reg_r[6];
   assign reg4007         = reg_r[7];
   assign p1_restart      = p1_restart_r;
   assign p2_restart      = p2_restart_r;
   assign p1_sweep_reload = p1_sweep_r;
   assign p2_sweep_reload = p2_sweep_r;
   assign p1_active       = (len1_r != 8'd0);
   assign p2_active       = (len2_r != 8'd0);
   assign cpu_data_out    = data_out_r;

endmodule

// File: tb/tb_apu_pulse_reg_writer.sv
// Scoreboard bench for apu_pulse_reg_writer: each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_apu_pulse_reg_writer;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_in;
   logic        cpu_we;
   logic        cpu_re;
   logic [7:0]  cpu_data_out;
   logic        half_frame_tick;
   logic [7:0]  reg4000, reg4001, reg4002, reg4003;
   logic [7:0]  reg4004, reg4005, reg4006, reg4007;
   logic        p1_restart, p2_restart, p1_sweep_reload, p2_sweep_reload;
   logic        p1_active, p2_active;

   typedef struct {
      int          id;
      logic [63:0] regs;
      logic [3:0]  strb;   // {p2_sweep, p1_sweep, p2_restart, p1_restart}
      logic [1:0]  act;    // {p2_active, p1_active}
      logic [7:0]  dout;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  e_regs [0:7];
   int          total;
   int          bad;
   int          step_id;

   apu_pulse_reg_writer dut (
      .clk             (clk),
      .reset           (reset),
      .cpu_addr        (cpu_addr),
      .cpu_data_in     (cpu_data_in),
      .cpu_we          (cpu_we),
      .cpu_re          (cpu_re),
      .cpu_data_out    (cpu_data_out),
      .half_frame_tick (half_frame_tick),
      .reg4000         (reg4000),
      .reg4001         (reg4001),
      .reg4002         (reg4002),
      .reg4003         (reg4003),
      .reg4004         (reg4004),
      .reg4005         (reg4005),
      .reg4006         (reg4006),
      .reg4007         (reg4007),
      .p1_restart      (p1_restart),
      .p2_restart      (p2_restart),
      .p1_sweep_reload (p1_sweep_reload),
      .p2_sweep_reload (p2_sweep_reload),
      .p1_active       (p1_active),
      .p2_active       (p2_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; expected outputs after that edge go to the scoreboard.
   task automatic step(input logic rst, input logic we, input logic re,
                       input logic [15:0] addr, input logic [7:0] data,
                       input logic tick, input logic [3:0] x_strb,
                       input logic [1:0] x_act, input logic [7:0] x_dout);
      exp_t e;
      reset           = rst;
      cpu_we          = we;
      cpu_re          = re;
      cpu_addr        = addr;
      cpu_data_in     = data;
      half_frame_tick = tick;
      if (rst) begin
         for (int i = 0; i < 8; i++) e_regs[i] = 8'h00;
      end else if (we && addr >= 16'h4000 && addr <= 16'h4007) begin
         e_regs[addr[2:0]] = data;
      end
      @(posedge clk);
      #1;
      step_id = step_id + 1;
      e.id   = step_id;
      e.regs = {e_regs[7], e_regs[6], e_regs[5], e_regs[4],
                e_regs[3], e_regs[2], e_regs[1], e_regs[0]};
      e.strb = x_strb;
      e.act  = x_act;
      e.dout = x_dout;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compares the DUT outputs against the oldest pending expectation.
   initial begin
      exp_t        e;
      logic [63:0] a_regs;
      logic [3:0]  a_strb;
      logic [1:0]  a_act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            a_regs = {reg4007, reg4006, reg4005, reg4004,
                      reg4003, reg4002, reg4001, reg4000};
            a_strb = {p2_sweep_reload, p1_sweep_reload, p2_restart, p1_restart};
            a_act  = {p2_active, p1_active};
            total  = total + 1;
            if (a_regs !== e.regs || a_strb !== e.strb ||
                a_act !== e.act || cpu_data_out !== e.dout) begin
               bad = bad + 1;
               $display("FAIL step%0d: got regs=%h strb=%b act=%b dout=%h, want regs=%h strb=%b act=%b dout=%h",
                        e.id, a_regs, a_strb, a_act, cpu_data_out,
                        e.regs, e.strb, e.act, e.dout);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // Directed vectors: args are rst, we, re, addr, data, tick, strb, act, dout.
   initial begin
      total   = 0;
      bad     = 0;
      step_id = 0;
      for (int i = 0; i < 8; i++) e_regs[i] = 8'h00;
      reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
      cpu_addr = 16'h0000; cpu_data_in = 8'h00; half_frame_tick = 1'b0;

      // Reset overrides a same-cycle write.
      step(1'b1, 1'b1, 1'b0, 16'h4002, 8'hFF, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4002, 8'hA5, 1'b0, 4'b0000, 2'b00, 8'h00);
      // Enable pulse 1, load index 1 (254).
      step(1'b0, 1'b1, 1'b0, 16'h4015, 8'h01, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h08, 1'b0, 4'b0001, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b1, 16'h4015, 8'h00, 1'b0, 4'b0000, 2'b01, 8'h01);
      // Pulse 2 disabled: strobe fires, counter stays 0.
      step(1'b0, 1'b1, 1'b0, 16'h4007, 8'h08, 1'b0, 4'b0010, 2'b01, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4001, 8'h11, 1'b0, 4'b0100, 2'b01, 8'h00);
      // Back-to-back sweep writes give two separate strobes.
      step(1'b0, 1'b1, 1'b0, 16'h4005, 8'h22, 1'b0, 4'b1000, 2'b01, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4005, 8'h33, 1'b0, 4'b1000, 2'b01, 8'h00);
      // Disable concurrent with a tick clears len1 from 254.
      step(1'b0, 1'b1, 1'b0, 16'h4015, 8'h00, 1'b1, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b0, 1'b1, 16'h4015, 8'h00, 1'b0, 4'b0000, 2'b00, 8'h00);
      // len1 = 2 with halt clear: 2 -> 1 -> 0 -> 0.
      step(1'b0, 1'b1, 1'b0, 16'h4015, 8'h01, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h18, 1'b0, 4'b0001, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b00, 8'h00);
      // Halt set: len1 = 2 holds through two ticks.
      step(1'b0, 1'b1, 1'b0, 16'h4000, 8'h20, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h18, 1'b0, 4'b0001, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b01, 8'h00);
      // Halt clear; then load index 3 together with a tick: 2, not 1.
      step(1'b0, 1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 4'b0000, 2'b01, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h18, 1'b1, 4'b0001, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b01, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 4'b0000, 2'b00, 8'h00);
      // Write and read together on $4015: write happens, read data is 0.
      step(1'b0, 1'b1, 1'b1, 16'h4015, 8'h03, 1'b0, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h08, 1'b0, 4'b0001, 2'b01, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4007, 8'h10, 1'b0, 4'b0010, 2'b11, 8'h00);
      step(1'b0, 1'b0, 1'b1, 16'h4015, 8'h00, 1'b0, 4'b0000, 2'b11, 8'h03);
      // Pulse registers are write-only; out-of-range writes are ignored.
      step(1'b0, 1'b0, 1'b1, 16'h4003, 8'h00, 1'b0, 4'b0000, 2'b11, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h4008, 8'hFF, 1'b0, 4'b0000, 2'b11, 8'h00);
      step(1'b0, 1'b1, 1'b0, 16'h3FFF, 8'hFF, 1'b0, 4'b0000, 2'b11, 8'h00);
      // Reset with a $4001 write, read and tick pending: everything cleared.
      step(1'b1, 1'b1, 1'b1, 16'h4001, 8'h44, 1'b1, 4'b0000, 2'b00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000, 2'b00, 8'h00);
      // Enables were cleared by reset: load is ignored, strobe still fires.
      step(1'b0, 1'b1, 1'b0, 16'h4003, 8'h08, 1'b0, 4'b0001, 2'b00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000, 2'b00, 8'h00);

      for (int i = 0; i < 10; i++) begin
         if (sb_q.size() != 0) @(negedge clk);
      end
      if (sb_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
